// File: rtl/bin_power_accum.sv
// Per-bin power accumulator: sums signed product terms with saturation, then scales
// and clamps each bin sum to an unsigned pixel delivered over valid/ready.
module bin_power_accum #(
    parameter int IN_W  = 32,
    parameter int ACC_W = 40,
    parameter int OUT_W = 8,
    parameter int SHIFT = 16,
    parameter int BINS  = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     prod_valid,
    output logic                     prod_ready,
    input  logic [IN_W-1:0]          prod,
    input  logic                     prod_last,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic [OUT_W-1:0]         pix,
    output logic [$clog2(BINS)-1:0]  pix_bin,
    output logic                     pix_eol,
    output logic                     ovf_sticky,
    input  logic                     clear_ovf
);
    localparam int BIN_W = $clog2(BINS);
    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_ACCUM = 1'b1;

    logic [0:0]              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    pix_valid_q, pix_valid_d;
    logic [OUT_W-1:0]        pix_q, pix_d;
    logic [BIN_W-1:0]        pix_bin_q, pix_bin_d;
    logic                    pix_eol_q, pix_eol_d;
    logic                    ovf_q, ovf_d;
    logic [BIN_W-1:0]        bin_cnt_q, bin_cnt_d;

    logic                    accept;
    logic signed [ACC_W-1:0] acc_base;
    logic [ACC_W:0]          sum_wide;
    logic                    sat;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] scaled;
    logic                    clamp;

    always_comb begin
        prod_ready = !pix_valid_q | pix_ready;
        accept     = prod_valid & prod_ready;
        // EMPTY means no term taken yet, so the base is zero regardless of acc_q
        acc_base   = (state_q == S_ACCUM) ? acc_q : '0;
        sum_wide   = {acc_base[ACC_W-1], acc_base} + {{(ACC_W+1-IN_W){prod[IN_W-1]}}, prod};
        sat        = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
        if (sat)
            sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            sum = sum_wide[ACC_W-1:0];
        scaled = sum >>> SHIFT;
        clamp  = |scaled[ACC_W-1:OUT_W];
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        pix_valid_d = pix_valid_q & !pix_ready;
        pix_d       = pix_q;
        pix_bin_d   = pix_bin_q;
        pix_eol_d   = pix_eol_q;
        bin_cnt_d   = bin_cnt_q;
        ovf_d       = clear_ovf ? 1'b0 : ovf_q;
        if (accept) begin
            if (sat)
                ovf_d = 1'b1;
            if (prod_last) begin
                state_d     = S_EMPTY;
                acc_d       = '0;
                pix_valid_d = 1'b1;
                pix_bin_d   = bin_cnt_q;
                pix_eol_d   = (bin_cnt_q == BIN_W'(BINS-1));
                bin_cnt_d   = bin_cnt_q + BIN_W'(1);
                if (sum[ACC_W-1]) begin
                    pix_d = '0;
                end else if (clamp) begin
                    pix_d = '1;
                    ovf_d = 1'b1;
                end else begin
                    pix_d = scaled[OUT_W-1:0];
                end
            end else begin
                state_d = S_ACCUM;
                acc_d   = sum;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_EMPTY;
            acc_q       <= '0;
            pix_valid_q <= 1'b0;
            pix_q       <= '0;
            pix_bin_q   <= '0;
            pix_eol_q   <= 1'b0;
            ovf_q       <= 1'b0;
            bin_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            pix_valid_q <= pix_valid_d;
            pix_q       <= pix_d;
            pix_bin_q   <= pix_bin_d;
            pix_eol_q   <= pix_eol_d;
            ovf_q       <= ovf_d;
            bin_cnt_q   <= bin_cnt_d;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix        = pix_q;
    assign pix_bin    = pix_bin_q;
    assign pix_eol    = pix_eol_q;
    assign ovf_sticky = ovf_q;
endmodule

// File: tb/tb_bin_power_accum.sv
// Directed bench for bin_power_accum: hand-computed pixels, handshake stalls,
// line wrap, accumulator saturation and mid-bin reset.
module tb_bin_power_accum;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        prod_valid = 1'b0;
    logic        prod_ready;
    logic [31:0] prod = '0;
    logic        prod_last = 1'b0;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic [7:0]  pix;
    logic [5:0]  pix_bin;
    logic        pix_eol;
    logic        ovf_sticky;
    logic        clear_ovf = 1'b0;

    int checks = 0;
    int errors = 0;

    bin_power_accum dut (
        .clk(clk), .reset_n(reset_n), .prod_valid(prod_valid), .prod_ready(prod_ready),
        .prod(prod), .prod_last(prod_last), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix(pix), .pix_bin(pix_bin), .pix_eol(pix_eol), .ovf_sticky(ovf_sticky),
        .clear_ovf(clear_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] p, input logic last);
        prod_valid = 1'b1;
        prod       = p;
        prod_last  = last;
        step();
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++;
        if ({pix_valid, pix, pix_bin, pix_eol, ovf_sticky} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b pix=%0d bin=%0d eol=%b ovf=%b want all 0",
                     pix_valid, pix, pix_bin, pix_eol, ovf_sticky);
        end
        checks++;
        if (prod_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_prod_ready got %b want 1", prod_ready);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        send(32'd4000000, 1'b0);
        send(32'd1000000, 1'b1);
        checks++;
        if ({pix_valid, pix, pix_bin, pix_eol, ovf_sticky} !== {1'b1, 8'd76, 6'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_pixel got v=%b pix=%0d bin=%0d eol=%b ovf=%b want 1 76 0 0 0",
                     pix_valid, pix, pix_bin, pix_eol, ovf_sticky);
        end
        step();
        checks++;
        if (pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_consume got pix_valid=%b want 0", pix_valid);
        end
    endtask

    task automatic test_clamp();
        send(32'd1073676289, 1'b0);
        send(32'd1073676289, 1'b1);
        checks++;
        if ({pix, pix_bin, ovf_sticky} !== {8'd255, 6'd1, 1'b1}) begin
            errors++;
            $display("FAIL clamp_pixel got pix=%0d bin=%0d ovf=%b want 255 1 1", pix, pix_bin, ovf_sticky);
        end
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        checks++;
        if (ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL clamp_clear got ovf=%b want 0", ovf_sticky);
        end
    endtask

    task automatic test_negative();
        send(-32'sd500000, 1'b1);
        checks++;
        if ({pix_valid, pix, pix_bin, ovf_sticky} !== {1'b1, 8'd0, 6'd2, 1'b0}) begin
            errors++;
            $display("FAIL negative_pixel got v=%b pix=%0d bin=%0d ovf=%b want 1 0 2 0",
                     pix_valid, pix, pix_bin, ovf_sticky);
        end
        step();
    endtask

    task automatic test_back_to_back();
        pix_ready = 1'b0;
        send(32'd196608, 1'b1);
        checks++;
        if ({pix_valid, pix, pix_bin, prod_ready} !== {1'b1, 8'd3, 6'd3, 1'b0}) begin
            errors++;
            $display("FAIL stall_first got v=%b pix=%0d bin=%0d rdy=%b want 1 3 3 0",
                     pix_valid, pix, pix_bin, prod_ready);
        end
        prod_valid = 1'b1;
        prod       = 32'd327680;
        prod_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({pix_valid, pix, pix_bin, prod_ready} !== {1'b1, 8'd3, 6'd3, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got v=%b pix=%0d bin=%0d rdy=%b want 1 3 3 0",
                         i, pix_valid, pix, pix_bin, prod_ready);
            end
        end
        pix_ready = 1'b1;
        step();
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        checks++;
        if ({pix_valid, pix, pix_bin} !== {1'b1, 8'd5, 6'd4}) begin
            errors++;
            $display("FAIL b2b_reload got v=%b pix=%0d bin=%0d want 1 5 4", pix_valid, pix, pix_bin);
        end
        step();
        checks++;
        if (pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got pix_valid=%b want 0", pix_valid);
        end
    endtask

    task automatic test_line_wrap();
        logic [5:0] exp_bin;
        exp_bin = 6'd5;
        for (int b = 0; b < 64; b++) begin
            send(32'd65536, 1'b0);
            send(32'd65536, 1'b1);
            checks++;
            if ({pix_valid, pix, pix_bin, pix_eol} !== {1'b1, 8'd2, exp_bin, (exp_bin == 6'd63)}) begin
                errors++;
                $display("FAIL line_bin iter %0d got v=%b pix=%0d bin=%0d eol=%b want 1 2 %0d %b",
                         b, pix_valid, pix, pix_bin, pix_eol, exp_bin, (exp_bin == 6'd63));
            end
            exp_bin = exp_bin + 6'd1;
        end
        step();
    endtask

    task automatic test_acc_saturation();
        for (int i = 0; i < 256; i++)
            send(32'h8000_0000, 1'b0);
        checks++;
        if (ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL sat_exact_min got ovf=%b want 0", ovf_sticky);
        end
        clear_ovf = 1'b1;
        send(32'h8000_0000, 1'b1);
        clear_ovf = 1'b0;
        checks++;
        if ({pix_valid, pix, ovf_sticky} !== {1'b1, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL sat_set_wins got v=%b pix=%0d ovf=%b want 1 0 1", pix_valid, pix, ovf_sticky);
        end
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        checks++;
        if (ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear got ovf=%b want 0", ovf_sticky);
        end
    endtask

    task automatic test_reset_mid_bin();
        send(32'd3000000, 1'b1);
        send(32'd3000000, 1'b0);
        #2;
        reset_n = 1'b0;
        #2;
        checks++;
        if ({pix_valid, pix, pix_bin, pix_eol, ovf_sticky} !== 17'd0) begin
            errors++;
            $display("FAIL midreset_outputs got v=%b pix=%0d bin=%0d eol=%b ovf=%b want all 0",
                     pix_valid, pix, pix_bin, pix_eol, ovf_sticky);
        end
        reset_n = 1'b1;
        step();
        send(32'd131072, 1'b1);
        checks++;
        if ({pix_valid, pix, pix_bin} !== {1'b1, 8'd2, 6'd0}) begin
            errors++;
            $display("FAIL midreset_next got v=%b pix=%0d bin=%0d want 1 2 0", pix_valid, pix, pix_bin);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_negative();
        test_back_to_back();
        test_line_wrap();
        test_acc_saturation();
        test_reset_mid_bin();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
